// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the program counter, fetches from instruction memory over a
//   req/ready handshake and buffers one instruction for decode. Next PC is
//   one of: sequential PC+4, branch target, J-type jump target, JR register.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   imem_req/addr         fetch request and address (= pc)
//   imem_ready/rdata      memory response; transfer = imem_req & imem_ready
//   instr_valid/instr     buffered instruction for decode
//   instr_pc/instr_pc4    address of buffered instruction and address + 4
//   stall                 decode cannot accept the buffered instruction
//   br_taken/br_offset    taken branch and its 16-bit word offset
//   jump                  J/JAL on buffered instruction
//   jr/jr_target          JR on buffered instruction and its register value
//   redirect_flush        one-cycle pulse after a taken control transfer
//   misaligned            sticky: JR target not word aligned (block halts)
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        redirect_flush,
  output logic        misaligned
);

  typedef enum logic {S_FETCH = 1'b0, S_ERROR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        flush_q, flush_d;
  logic        misaligned_q, misaligned_d;

  logic        consume, redirect, jr_bad, xfer;
  logic [31:0] jmp_tgt, br_tgt, tgt;

  assign consume   = instr_valid_q & ~stall;
  assign redirect  = consume & (jr | jump | br_taken);
  // jr has top priority, so a misaligned JR halts even if jump/br also set
  assign jr_bad    = redirect & jr & (|jr_target[1:0]);
  assign xfer      = imem_req & imem_ready;

  assign instr_pc4 = instr_pc_q + 32'd4;
  // Jump uses instr_pc4 upper bits so a wrapped PC selects the new region
  assign jmp_tgt   = {instr_pc4[31:28], instr_q[25:0], 2'b00};
  assign br_tgt    = instr_pc4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign tgt       = jr ? jr_target : (jump ? jmp_tgt : br_tgt);

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    if (state_q == S_FETCH && jr_bad) state_d = S_ERROR;
  end

  // ---- FSM: outputs ----
  // rst_n gates the request so it drops the moment reset is asserted
  always_comb begin
    imem_req = rst_n & (state_q == S_FETCH) & (~instr_valid_q | consume) & ~redirect;
  end

  // ---- datapath next values ----
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    flush_d       = 1'b0;
    misaligned_d  = misaligned_q;
    if (state_q == S_FETCH) begin
      if (jr_bad) begin
        instr_valid_d = 1'b0;
        misaligned_d  = 1'b1;
      end else if (redirect) begin
        pc_d          = tgt;
        instr_valid_d = 1'b0;
        flush_d       = 1'b1;
      end else if (xfer) begin
        instr_d       = imem_rdata;
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
        pc_d          = pc_q + 32'd4;
      end else if (consume) begin
        instr_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'd0;
      instr_pc_q    <= RESET_VECTOR;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      flush_q       <= flush_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_valid    = instr_valid_q & (state_q == S_FETCH);
  assign redirect_flush = flush_q;
  assign misaligned     = misaligned_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch from instruction memory over a req/ready handshake. It buffers one fetched instruction for decode. It computes the next PC from one of four sources: sequential PC+4, branch target, J-type jump target ({PC+4[31:28], instr[25:0], 2'b00}), or register target for JR. It sits between instruction memory and the decode stage and replaces the free-running PC register plus next-PC mux.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request; address valid while high
imem_addr  out  32  fetch address (= current pc)
imem_ready  in  1  memory returns imem_rdata this cycle; transfer = imem_req & imem_ready
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/instr_pc hold an undecoded instruction
instr  out  32  buffered instruction
instr_pc  out  32  address of buffered instruction
instr_pc4  out  32  instr_pc + 4
stall  in  1  decode cannot accept the buffered instruction this cycle
br_taken  in  1  buffered instruction is a taken branch
br_offset  in  16  branch immediate (instr[15:0])
jump  in  1  buffered instruction is J/JAL
jr  in  1  buffered instruction is JR
jr_target  in  32  register value for JR
redirect_flush  out  1  one-cycle pulse: control transfer taken, fetch discarded
misaligned  out  1  sticky: JR target not word aligned

Behaviour:
- Asynchronous reset (rst_n=0): pc=RESET_VECTOR, state=FETCH, instr_valid=0, instr=0, instr_pc=RESET_VECTOR, redirect_flush=0, misaligned=0. While in reset, imem_req=0.
- States:
  - FETCH: normal operation.
  - ERROR: terminal until reset. imem_req=0 and instr_valid=0.
- consume = instr_valid & ~stall.
- Redirect inputs (jr, jump, br_taken) are sampled only when consume=1 and are ignored otherwise.
- Redirect priority: jr > jump > br_taken > none.
- Target arithmetic (all modulo 2^32):
  - Jump target = {instr_pc4[31:28], instr[25:0], 2'b00}.
  - Branch target = instr_pc4 + {{14{br_offset[15]}}, br_offset, 2'b00}.
  - JR target = jr_target.
- redirect = consume & (jr | jump | br_taken).
- imem_req (combinational) = (state==FETCH) & (~instr_valid | consume) & ~redirect.
- Fetch transfer (imem_req & imem_ready) at the edge:
  - instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
  - Fetch latency: 1 cycle from ready to instr_valid.
  - Back-to-back transfers every cycle are legal when decode never stalls.
- consume without transfer and without redirect: instr_valid<=0.
- Redirect at the edge:
  - pc<=target, instr_valid<=0, redirect_flush<=1 for exactly one cycle.
  - No delay slot.
  - imem_ready in that cycle is ignored, because imem_req=0.
- JR with jr_target[1:0]!=0:
  - state<=ERROR, misaligned<=1, instr_valid<=0, pc unchanged.
  - redirect_flush is not asserted.
- stall with instr_valid=1: instr, instr_pc and pc hold, and imem_req=0.
- pc wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Jump target uses instr_pc4, so it takes the post-wrap upper bits.
- rst_n asserted mid-handshake: everything returns to reset values immediately. Memory must tolerate a dropped request.
- Simultaneous jump and br_taken: jump wins.
- Simultaneous jr and jump: jr wins, including the misaligned check.

Test Plan:
- Reset, imem_ready=1 constantly, no stall → imem_addr 0,4,8,C on consecutive cycles; instr_valid rises 1 cycle after first ready; instr_pc follows 0,4,8.
- Buffered instr at 32'h1000_0040 with jump=1, instr[25:0]=26'h0000100 → next imem_addr=32'h1000_0400; redirect_flush high exactly one cycle; instr_valid=0 that cycle.
- Buffered instr at 32'h0000_0100, br_taken=1, br_offset=16'hFFFE → next pc=32'h0000_00FC. Same setup with br_offset=16'h0003 → next pc=32'h0000_0110.
- stall=1 for 3 cycles with instr_valid=1 → imem_req=0, instr/instr_pc stable, pc unchanged. Stall release with no redirect → fetch resumes at held pc.
- jr=1, jump=1, jr_target=32'h0000_2002 → misaligned=1, imem_req=0 permanently, no flush. rst_n pulse → pc=RESET_VECTOR, misaligned=0.
- pc=32'hFFFF_FFFC fetched → next imem_addr=0. rst_n low during imem_req with imem_ready=0 → imem_req drops asynchronously, and the restart fetch is at RESET_VECTOR.
